// File: rtl/decrement_counter_if.sv
// Handshake bundle for the loadable down-counter: control inputs from the
// owning block and the registered status outputs of the counter.
interface decrement_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] start;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] current;
  logic             busy;
  logic             done;

  // Controller side: drives the load/enable controls, observes the count.
  modport master (
    output load, start, en, auto_reload,
    input  current, busy, done
  );

  // Counter side: consumes the controls, drives the registered status.
  modport slave (
    input  load, start, en, auto_reload,
    output current, busy, done
  );
endinterface

// File: rtl/decrement_counter.sv
// Loadable down-counter with prescaler, one-shot / auto-reload modes and a
// one-cycle done pulse on expiry. All outputs come straight from registers.
module decrement_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1   // enabled cycles per decrement, must be >= 1
) (
  input logic                clk,
  input logic                rst,
  decrement_counter_if.slave bus
);

  // Prescale counter only needs to reach PRESCALE-1; keep at least one bit.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] cur_next;
  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] rld_next;
  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_next;
  logic             done_pulse;
  logic             done_next;

  // Next-state logic: load beats a tick; ticks only happen in RUN with en high.
  always_comb begin
    state_next = state;
    cur_next   = cur;
    rld_next   = rld;
    pre_next   = pre;
    done_next  = 1'b0;

    if (bus.load) begin
      rld_next = bus.start;
      cur_next = bus.start;
      pre_next = PRE_ZERO;
      if (bus.start != CNT_ZERO) begin
        state_next = RUN;
      end else begin
        // Loading zero is an immediate expiry: flag it and stay idle.
        state_next = IDLE;
        done_next  = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          // Idle ignores en; everything holds until the next load.
          pre_next = pre;
        end
        RUN: begin
          if (bus.en) begin
            if (pre == PRE_LAST) begin
              pre_next = PRE_ZERO;
              if (cur == CNT_ONE) begin
                done_next = 1'b1;
                if (bus.auto_reload) begin
                  cur_next = rld;
                end else begin
                  cur_next   = CNT_ZERO;
                  state_next = IDLE;
                end
              end else if (cur > CNT_ONE) begin
                cur_next = cur - CNT_ONE;
              end else begin
                // cur == 0 cannot occur in RUN; hold rather than wrap.
                cur_next = cur;
              end
            end else begin
              pre_next = pre + PRE_ONE;
            end
          end else begin
            // en low stretches the interval without losing prescale progress.
            pre_next = pre;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset to an idle, zero count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= CNT_ZERO;
      rld        <= CNT_ZERO;
      pre        <= PRE_ZERO;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cur        <= cur_next;
      rld        <= rld_next;
      pre        <= pre_next;
      done_pulse <= done_next;
    end
  end

  assign bus.current = cur;
  assign bus.busy    = (state == RUN);
  assign bus.done    = done_pulse;

endmodule

// File: tb/tb_decrement_counter.sv
// Self-checking bench: two counters (PRESCALE 1 and 3) share stimulus and are
// compared every cycle against a behavioural model, plus directed checks.
module tb_decrement_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] start;
  logic       en;
  logic       auto_reload;

  int vectors;
  int miscompares;

  decrement_counter_if #(.WIDTH(4)) bus_p1 ();
  decrement_counter_if #(.WIDTH(4)) bus_p3 ();

  assign bus_p1.load        = load;
  assign bus_p1.start       = start;
  assign bus_p1.en          = en;
  assign bus_p1.auto_reload = auto_reload;
  assign bus_p3.load        = load;
  assign bus_p3.start       = start;
  assign bus_p3.en          = en;
  assign bus_p3.auto_reload = auto_reload;

  decrement_counter #(.WIDTH(4), .PRESCALE(1)) dut_p1 (.clk(clk), .rst(rst), .bus(bus_p1));
  decrement_counter #(.WIDTH(4), .PRESCALE(3)) dut_p3 (.clk(clk), .rst(rst), .bus(bus_p3));

  logic [3:0] cur_o  [2];
  logic       busy_o [2];
  logic       done_o [2];
  assign cur_o[0]  = bus_p1.current;
  assign busy_o[0] = bus_p1.busy;
  assign done_o[0] = bus_p1.done;
  assign cur_o[1]  = bus_p3.current;
  assign busy_o[1] = bus_p3.busy;
  assign done_o[1] = bus_p3.done;

  // Behavioural model: "left" = enabled cycles still needed before the next step.
  int         pres [2] = '{1, 3};
  logic [3:0] m_cur  [2];
  logic [3:0] m_rld  [2];
  int         m_left [2];
  logic       m_run  [2];
  logic       m_done [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cur[k] = 4'd0; m_rld[k] = 4'd0; m_left[k] = pres[k];
      m_run[k] = 1'b0; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    if (load) begin
      m_rld[k]  = start;
      m_cur[k]  = start;
      m_left[k] = pres[k];
      m_run[k]  = (start != 4'd0);
      m_done[k] = (start == 4'd0);
    end else begin
      m_done[k] = 1'b0;
      if (m_run[k] && en) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_left[k] = pres[k];
          if (m_cur[k] == 4'd1) begin
            m_done[k] = 1'b1;
            if (auto_reload) m_cur[k] = m_rld[k];
            else begin m_cur[k] = 4'd0; m_run[k] = 1'b0; end
          end else begin
            m_cur[k] = m_cur[k] - 4'd1;
          end
        end
      end
    end
  endtask

  // Advance the model with the present inputs, then take one clock edge.
  task automatic advance();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; start = 4'd0; en = 1'b0; auto_reload = 1'b0;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cur_o[k] !== 4'd0 || busy_o[k] !== 1'b0 || done_o[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_initial dut%0d: current=%0d busy=%b done=%b, want 0/0/0",
                 k, cur_o[k], busy_o[k], done_o[k]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // Count to 7 on the PRESCALE=1 counter, then reset with no clock edge.
    load = 1'b1; start = 4'd9; en = 1'b1;
    advance();
    load = 1'b0;
    advance();
    advance();
    vectors++;
    if (cur_o[0] !== 4'd7) begin
      miscompares++;
      $display("FAIL reset_precount: current=%0d, want 7", cur_o[0]);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cur_o[k] !== 4'd0 || busy_o[k] !== 1'b0 || done_o[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_midcount dut%0d: current=%0d busy=%b done=%b, want 0/0/0",
                 k, cur_o[k], busy_o[k], done_o[k]);
      end
    end
    rst = 1'b0;
    // After release, en alone must not start anything.
    for (int c = 0; c < 3; c++) begin
      advance();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (cur_o[k] !== m_cur[k] || busy_o[k] !== m_run[k] || done_o[k] !== m_done[k]) begin
          miscompares++;
          $display("FAIL reset_idle dut%0d: current=%0d busy=%b done=%b, want %0d/%b/%b",
                   k, cur_o[k], busy_o[k], done_o[k], m_cur[k], m_run[k], m_done[k]);
        end
      end
    end
  endtask

  task automatic test_one_shot();
    load = 1'b1; start = 4'd5; en = 1'b1; auto_reload = 1'b0;
    for (int i = 0; i < 9; i++) begin
      advance();
      load = 1'b0;
      vectors++;
      if (cur_o[0] !== ((i < 5) ? 4'(5 - i) : 4'd0) || busy_o[0] !== (i < 5) ||
          done_o[0] !== (i == 5)) begin
        miscompares++;
        $display("FAIL one_shot_seq edge%0d: current=%0d busy=%b done=%b", i,
                 cur_o[0], busy_o[0], done_o[0]);
      end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (cur_o[k] !== m_cur[k] || busy_o[k] !== m_run[k] || done_o[k] !== m_done[k]) begin
          miscompares++;
          $display("FAIL one_shot dut%0d edge%0d: current=%0d busy=%b done=%b, want %0d/%b/%b",
                   k, i, cur_o[k], busy_o[k], done_o[k], m_cur[k], m_run[k], m_done[k]);
        end
      end
    end
  endtask

  task automatic test_auto_reload_prescale();
    load = 1'b1; start = 4'd2; en = 1'b1; auto_reload = 1'b1;
    for (int i = 0; i < 14; i++) begin
      advance();
      load = 1'b0;
      vectors++;
      if (cur_o[1] !== (((i % 6) < 3) ? 4'd2 : 4'd1) || busy_o[1] !== 1'b1 ||
          done_o[1] !== (i > 0 && (i % 6) == 0)) begin
        miscompares++;
        $display("FAIL auto_reload_seq edge%0d: current=%0d busy=%b done=%b", i,
                 cur_o[1], busy_o[1], done_o[1]);
      end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (cur_o[k] !== m_cur[k] || busy_o[k] !== m_run[k] || done_o[k] !== m_done[k]) begin
          miscompares++;
          $display("FAIL auto_reload dut%0d edge%0d: current=%0d busy=%b done=%b, want %0d/%b/%b",
                   k, i, cur_o[k], busy_o[k], done_o[k], m_cur[k], m_run[k], m_done[k]);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [3:0] exp_cur [8] = '{4'd4, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    auto_reload = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load  = (i == 0);
      start = 4'd4;
      en    = !(i >= 2 && i <= 4);
      advance();
      vectors++;
      if (cur_o[0] !== exp_cur[i] || done_o[0] !== (i == 7)) begin
        miscompares++;
        $display("FAIL enable_gating edge%0d: current=%0d done=%b, want %0d/%b", i,
                 cur_o[0], done_o[0], exp_cur[i], (i == 7));
      end
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (cur_o[k] !== m_cur[k] || busy_o[k] !== m_run[k] || done_o[k] !== m_done[k]) begin
          miscompares++;
          $display("FAIL enable_model dut%0d edge%0d: current=%0d busy=%b done=%b, want %0d/%b/%b",
                   k, i, cur_o[k], busy_o[k], done_o[k], m_cur[k], m_run[k], m_done[k]);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reload_collision();
    load = 1'b1; start = 4'd1; en = 1'b1; auto_reload = 1'b0;
    advance();
    // The next edge would expire the PRESCALE=1 counter; load wins.
    start = 4'hF;
    advance();
    load = 1'b0;
    vectors++;
    if (cur_o[0] !== 4'd15 || busy_o[0] !== 1'b1 || done_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_collision: current=%0d busy=%b done=%b, want 15/1/0",
               cur_o[0], busy_o[0], done_o[0]);
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cur_o[k] !== m_cur[k] || busy_o[k] !== m_run[k] || done_o[k] !== m_done[k]) begin
        miscompares++;
        $display("FAIL reload_after dut%0d: current=%0d busy=%b done=%b, want %0d/%b/%b",
                 k, cur_o[k], busy_o[k], done_o[k], m_cur[k], m_run[k], m_done[k]);
      end
    end
  endtask

  task automatic test_zero_load();
    load = 1'b1; start = 4'd0;
    advance();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (cur_o[k] !== 4'd0 || busy_o[k] !== 1'b0 || done_o[k] !== 1'b1) begin
        miscompares++;
        $display("FAIL zero_load dut%0d: current=%0d busy=%b done=%b, want 0/0/1",
                 k, cur_o[k], busy_o[k], done_o[k]);
      end
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (done_o[k] !== 1'b0 || busy_o[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_load_after dut%0d: busy=%b done=%b, want 0/0",
                 k, busy_o[k], done_o[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load        = ($urandom_range(0, 7) == 0);
      start       = 4'($urandom_range(0, 15));
      en          = ($urandom_range(0, 3) != 0);
      auto_reload = ($urandom_range(0, 1) == 1);
      advance();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (cur_o[k] !== m_cur[k] || busy_o[k] !== m_run[k] || done_o[k] !== m_done[k]) begin
          miscompares++;
          $display("FAIL random dut%0d cyc%0d: current=%0d busy=%b done=%b, want %0d/%b/%b",
                   k, i, cur_o[k], busy_o[k], done_o[k], m_cur[k], m_run[k], m_done[k]);
        end
      end
    end
    load = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_one_shot();
    test_auto_reload_prescale();
    test_enable_gating();
    test_reload_collision();
    test_zero_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decrement_counter.md
# decrement_counter

Loadable down-counter: the counting-down counterpart to the team's increment counter. It latches a start value, decrements it once per enabled tick, and flags expiry with a one-cycle `done` pulse. In one-shot mode it then stops. In auto-reload mode it restarts from the latched value, which makes it a periodic event generator. It sits beside the increment counter in the counter/timer section and is driven by the same clock.

## Interface
- `WIDTH`, default 4: bit width of the start value and the count.
- `PRESCALE`, default 1: number of enabled clock cycles per decrement. Must be ≥ 1.

- `clk`  input  1  system clock, rising-edge active.
- `rst`  input  1  asynchronous reset, active-high.
- `load`  input  1  when high at a clock edge, latches `start` and (re)starts counting.
- `start`  input  WIDTH  initial/reload value, sampled only when `load` is high.
- `en`  input  1  count enable; the prescaler advances only while `en` is high.
- `auto_reload`  input  1  sampled at each expiry: 1 = reload and continue, 0 = stop.
- `current`  output  WIDTH  present count value.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse on expiry.

## Operation
- Registers:
  - `cur` drives `current`.
  - `rld` holds the latched start value.
  - `pre` is the prescale counter, width max(1, clog2(PRESCALE)).
  - `state` is a two-state FSM.
- States:
  - IDLE: not counting; `busy` = 0.
  - RUN: counting; `busy` = 1.
- A tick occurs in RUN when `en` = 1 and `pre` == PRESCALE-1. On a tick `pre` returns to 0. Otherwise, while `en` = 1, `pre` increments. While `en` = 0, `pre` holds.
- On a tick with `cur` > 1: `cur` ← `cur` - 1.
- Expiry is a tick with `cur` == 1. It asserts `done` for one cycle, then:
  - if `auto_reload` = 1: `cur` ← `rld`, stay in RUN;
  - if `auto_reload` = 0: `cur` ← 0, go to IDLE.
- `load` (any state) has priority over a tick in the same cycle:
  - `rld` ← `start`, `cur` ← `start`, `pre` ← 0;
  - if `start` ≠ 0: state ← RUN;
  - if `start` == 0: state ← IDLE, and `done` pulses on the same edge (immediate expiry).
- IDLE ignores `en`. `cur` never decrements below 0, and there is no wrap-around.
- Arithmetic is unsigned modulo 2^WIDTH. The maximum start value is 2^WIDTH-1 (4'hF for the default).
- An auto-reload period is exactly `rld` ticks; `current` shows `rld`..1 and never shows 0 in this mode.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-count):
  - `current` = 0, `busy` = 0, `done` = 0;
  - state = IDLE, `rld` = 0, `pre` = 0.
- Deassertion of `rst` is honored at the next edge; the block stays in IDLE until `load`.
- All outputs are registered; there is no combinational path from input to output.
- Load latency: `current` = `start` and `busy` = 1 on the first edge where `load` = 1.
- With PRESCALE = 1 and `en` held high:
  - `current` = `start` - N at N edges after the load edge;
  - `done` is high for the single cycle following edge `start` (counted from the load edge);
  - `busy` falls on the same edge in one-shot mode.
- With PRESCALE = P: each decrement takes P enabled cycles. Cycles with `en` low stretch the interval and do not lose progress.
- `done` and `load` on the same edge: `load` wins, so there is no `done` unless `start` == 0.
- `auto_reload` is sampled only on the expiry edge. Changing it mid-count has no other effect.

## Test plan
- Reset: assert `rst` mid-count with `current` = 7 → `current` = 0, `busy` = 0, `done` = 0 immediately, with no clock edge required.
- One-shot: WIDTH = 4, PRESCALE = 1, `load` with `start` = 4'd5, `en` = 1, `auto_reload` = 0 → `current` goes 5, 4, 3, 2, 1, 0. `done` is high for exactly one cycle alongside `current` = 0, `busy` drops at the same time, and `current` stays 0 afterwards.
- Auto-reload + prescale: PRESCALE = 3, `start` = 4'd2, `auto_reload` = 1 → `current` sequence 2, 2, 2, 1, 1, 1, 2, …; `done` pulses every 6 cycles; `busy` stays 1.
- Enable gating: PRESCALE = 1, `start` = 4'd4; drop `en` for 3 cycles after `current` = 3 → `current` holds at 3 for 3 cycles, then resumes 2, 1, 0. Total load-to-`done` time is 7 cycles.
- Reload collision: `load` `start` = 4'hF asserted on the expiry edge of a count from 1 → `current` = 15, `busy` = 1, no `done` pulse.
- Zero load: `load` with `start` = 0 → `current` = 0, `busy` = 0, `done` high for one cycle.
